// File: rtl/reg_write_arbiter_if.sv
// Write-request handshake bundle shared by requester A (SPI decoder) and
// requester B (sequencer) toward the configuration register arbiter.
interface reg_write_arbiter_if;
   logic       a_req;
   logic [6:0] a_addr;
   logic [7:0] a_data;
   logic       a_ack;
   logic       b_req;
   logic [6:0] b_addr;
   logic [7:0] b_data;
   logic       b_ack;

   modport master (
      output a_req, a_addr, a_data, b_req, b_addr, b_data,
      input  a_ack, b_ack
   );

   modport slave (
      input  a_req, a_addr, a_data, b_req, b_addr, b_data,
      output a_ack, b_ack
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbitrated write port owning the five configuration registers.
// Optional REG_ARB_ERR_EN adds a_err/b_err out-of-range write indicators.
//
// state   | meaning
// IDLE    | waiting for a request; grant and latch addr/data on a request
// COMMIT  | write held data to the addressed register, raise the winner's ack
// RELEASE | drop ack, return to IDLE
module reg_write_arbiter #(
   parameter logic [6:0] MAX_ADDR = 7'h04
) (
   input  logic                clk,
   input  logic                rst_n,
   reg_write_arbiter_if.slave  bus,
   output logic                busy,
   output logic [7:0]          en_reg_out_7_0,
   output logic [7:0]          en_reg_out_15_8,
   output logic [7:0]          en_reg_pwm_7_0,
   output logic [7:0]          en_reg_pwm_15_8,
   output logic [7:0]          pwm_duty_cycle
`ifdef REG_ARB_ERR_EN
   ,
   output logic                a_err,
   output logic                b_err
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMMIT  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t     state;
   logic       grant_b;
   logic       last_grant_b;
   logic [6:0] hold_addr;
   logic [7:0] hold_data;
   logic       win_b;
   logic       in_range;

   // Under contention the requester that was not granted last wins.
   assign win_b    = bus.b_req & (~bus.a_req | ~last_grant_b);
   assign in_range = (hold_addr <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         grant_b         <= 1'b0;
         last_grant_b    <= 1'b1;
         hold_addr       <= 7'h00;
         hold_data       <= 8'h00;
         busy            <= 1'b0;
         bus.a_ack       <= 1'b0;
         bus.b_ack       <= 1'b0;
         en_reg_out_7_0  <= 8'h00;
         en_reg_out_15_8 <= 8'h00;
         en_reg_pwm_7_0  <= 8'h00;
         en_reg_pwm_15_8 <= 8'h00;
         pwm_duty_cycle  <= 8'h00;
`ifdef REG_ARB_ERR_EN
         a_err           <= 1'b0;
         b_err           <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.a_req | bus.b_req) begin
                  grant_b      <= win_b;
                  last_grant_b <= win_b;
                  hold_addr    <= win_b ? bus.b_addr : bus.a_addr;
                  hold_data    <= win_b ? bus.b_data : bus.a_data;
                  busy         <= 1'b1;
                  state        <= COMMIT;
               end
            end
            COMMIT: begin
               if (in_range) begin
                  case (hold_addr)
                     7'h00:   en_reg_out_7_0  <= hold_data;
                     7'h01:   en_reg_out_15_8 <= hold_data;
                     7'h02:   en_reg_pwm_7_0  <= hold_data;
                     7'h03:   en_reg_pwm_15_8 <= hold_data;
                     7'h04:   pwm_duty_cycle  <= hold_data;
                     default: ;
                  endcase
               end
               bus.a_ack <= ~grant_b;
               bus.b_ack <= grant_b;
`ifdef REG_ARB_ERR_EN
               a_err     <= ~grant_b & ~in_range;
               b_err     <= grant_b & ~in_range;
`endif
               state     <= RELEASE;
            end
            RELEASE: begin
               bus.a_ack <= 1'b0;
               bus.b_ack <= 1'b0;
`ifdef REG_ARB_ERR_EN
               a_err     <= 1'b0;
               b_err     <= 1'b0;
`endif
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by
// randomized requester traffic, checked every cycle against a transaction model.
`timescale 1ns/1ps
module tb_reg_write_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_write_arbiter_if bus ();
   logic       busy;
   logic [7:0] r0, r1, r2, r3, r4;
`ifdef REG_ARB_ERR_EN
   logic       a_err, b_err;
`endif

   reg_write_arbiter #(.MAX_ADDR(7'h04)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .busy            (busy),
      .en_reg_out_7_0  (r0),
      .en_reg_out_15_8 (r1),
      .en_reg_pwm_7_0  (r2),
      .en_reg_pwm_15_8 (r3),
      .pwm_duty_cycle  (r4)
`ifdef REG_ARB_ERR_EN
      ,
      .a_err           (a_err),
      .b_err           (b_err)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Transaction model: one write in flight, scheduled by edge number.
   logic [7:0] m_reg [5];
   logic       m_a_ack, m_b_ack, m_busy, m_last_b;
`ifdef REG_ARB_ERR_EN
   logic       m_a_err, m_b_err;
`endif
   bit         pend;
   bit         p_b;
   int         p_commit, p_done;
   logic [6:0] p_addr;
   logic [7:0] p_data;

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
      m_a_ack  = 1'b0;
      m_b_ack  = 1'b0;
      m_busy   = 1'b0;
      m_last_b = 1'b1;
`ifdef REG_ARB_ERR_EN
      m_a_err  = 1'b0;
      m_b_err  = 1'b0;
`endif
      pend     = 1'b0;
   endtask

   task automatic model_edge();
      bit can_grant;
      cyc++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      can_grant = !pend;
      m_a_ack = 1'b0;
      m_b_ack = 1'b0;
`ifdef REG_ARB_ERR_EN
      m_a_err = 1'b0;
      m_b_err = 1'b0;
`endif
      if (pend && cyc == p_commit) begin
         if (p_addr <= 7'd4) m_reg[p_addr[2:0]] = p_data;
         if (p_b) m_b_ack = 1'b1;
         else     m_a_ack = 1'b1;
`ifdef REG_ARB_ERR_EN
         if (p_b) m_b_err = (p_addr > 7'd4);
         else     m_a_err = (p_addr > 7'd4);
`endif
      end
      if (pend && cyc == p_done) pend = 1'b0;
      if (can_grant && (bus.a_req || bus.b_req)) begin
         if (bus.a_req && bus.b_req) p_b = !m_last_b;
         else                        p_b = bus.b_req;
         m_last_b = p_b;
         p_addr   = p_b ? bus.b_addr : bus.a_addr;
         p_data   = p_b ? bus.b_data : bus.a_data;
         p_commit = cyc + 1;
         p_done   = cyc + 2;
         pend     = 1'b1;
      end
      m_busy = pend;
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [7:0] dut_reg(input logic [6:0] addr);
      case (addr)
         7'h00:   return r0;
         7'h01:   return r1;
         7'h02:   return r2;
         7'h03:   return r3;
         default: return r4;
      endcase
   endfunction

   task automatic check_all();
      chk("a_ack", 40'(bus.a_ack), 40'(m_a_ack));
      chk("b_ack", 40'(bus.b_ack), 40'(m_b_ack));
      chk("busy",  40'(busy),      40'(m_busy));
      chk("regs",  {r4, r3, r2, r1, r0}, {m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
`ifdef REG_ARB_ERR_EN
      chk("a_err", 40'(a_err), 40'(m_a_err));
      chk("b_err", 40'(b_err), 40'(m_b_err));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_a(input logic req, input logic [6:0] addr, input logic [7:0] data);
      bus.a_req  = req;
      bus.a_addr = addr;
      bus.a_data = data;
   endtask

   task automatic set_b(input logic req, input logic [6:0] addr, input logic [7:0] data);
      bus.b_req  = req;
      bus.b_addr = addr;
      bus.b_data = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] bb_addr [4];
      logic [7:0] bb_data [4];
      int         ack_t   [4];
      int         n_ack;

      // Reset held with random inputs.
      rst_n = 1'b0;
      model_reset();
      repeat (4) begin
         set_a(1'($urandom), 7'($urandom), 8'($urandom));
         set_b(1'($urandom), 7'($urandom), 8'($urandom));
         cycle();
      end
      chk("reset_regs", {r4, r3, r2, r1, r0}, 40'h0);
      chk("reset_busy", 40'(busy), 40'h0);
      set_a(1'b0, 7'h00, 8'h00);
      set_b(1'b0, 7'h00, 8'h00);
      rst_n = 1'b1;
      cycle();

      // First contention after reset: A first, B three cycles later.
      set_a(1'b1, 7'h00, 8'h11);
      set_b(1'b1, 7'h00, 8'h22);
      cycle();
      cycle();
      chk("cont1_a_ack", 40'(bus.a_ack), 40'h1);
      chk("cont1_val_a", 40'(r0), 40'h11);
      set_a(1'b0, 7'h00, 8'h00);
      cycle();
      cycle();
      cycle();
      chk("cont1_b_ack", 40'(bus.b_ack), 40'h1);
      chk("cont1_val_b", 40'(r0), 40'h22);
      set_b(1'b0, 7'h00, 8'h00);
      cycle();

      // Single write from A.
      set_a(1'b1, 7'h02, 8'hA5);
      cycle();
      chk("single_no_early_ack", 40'(bus.a_ack), 40'h0);
      cycle();
      chk("single_a_ack", 40'(bus.a_ack), 40'h1);
      chk("single_val", 40'(r2), 40'hA5);
      set_a(1'b0, 7'h00, 8'h00);
      cycle();
      chk("single_ack_drop", 40'(bus.a_ack), 40'h0);

      // Last grant is A now, so B wins the next contention.
      set_a(1'b1, 7'h01, 8'h33);
      set_b(1'b1, 7'h01, 8'h44);
      cycle();
      cycle();
      chk("cont2_b_ack", 40'(bus.b_ack), 40'h1);
      chk("cont2_val_b", 40'(r1), 40'h44);
      set_b(1'b0, 7'h00, 8'h00);
      cycle();
      cycle();
      cycle();
      chk("cont2_a_ack", 40'(bus.a_ack), 40'h1);
      chk("cont2_val_a", 40'(r1), 40'h33);
      set_a(1'b0, 7'h00, 8'h00);
      cycle();

      // Out-of-range write from B is acked but changes nothing.
      set_b(1'b1, 7'h05, 8'hFF);
      cycle();
      cycle();
      chk("oor_b_ack", 40'(bus.b_ack), 40'h1);
      chk("oor_regs", {r4, r3, r2, r1, r0}, 40'h00_00_A5_33_22);
`ifdef REG_ARB_ERR_EN
      chk("oor_b_err", 40'(b_err), 40'h1);
`endif
      set_b(1'b0, 7'h00, 8'h00);
      cycle();

      // Reset asserted during COMMIT discards the write.
      set_a(1'b1, 7'h04, 8'h80);
      cycle();
      rst_n = 1'b0;
      model_reset();
      set_a(1'b0, 7'h00, 8'h00);
      #1;
      chk("midrst_duty", 40'(r4), 40'h0);
      chk("midrst_busy", 40'(busy), 40'h0);
      chk("midrst_ack", 40'(bus.a_ack), 40'h0);
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      set_a(1'b1, 7'h04, 8'h80);
      cycle();
      cycle();
      chk("postrst_a_ack", 40'(bus.a_ack), 40'h1);
      chk("postrst_duty", 40'(r4), 40'h80);
      set_a(1'b0, 7'h00, 8'h00);
      cycle();

      // Back-to-back: A keeps req high across four writes.
      bb_addr[0] = 7'h00; bb_addr[1] = 7'h01; bb_addr[2] = 7'h03; bb_addr[3] = 7'h04;
      for (int i = 0; i < 4; i++) bb_data[i] = 8'($urandom);
      n_ack = 0;
      set_a(1'b1, bb_addr[0], bb_data[0]);
      for (int k = 0; k < 40 && n_ack < 4; k++) begin
         cycle();
         if (bus.a_ack === 1'b1) begin
            ack_t[n_ack] = cyc;
            chk("b2b_val", 40'(dut_reg(bb_addr[n_ack])), 40'(bb_data[n_ack]));
            n_ack++;
         end
         if (m_a_ack) begin
            if (n_ack < 4) set_a(1'b1, bb_addr[n_ack], bb_data[n_ack]);
            else           set_a(1'b0, 7'h00, 8'h00);
         end
      end
      set_a(1'b0, 7'h00, 8'h00);
      chk("b2b_ack_count", 40'(n_ack), 40'd4);
      for (int i = 1; i < n_ack; i++)
         chk("b2b_spacing", 40'(ack_t[i] - ack_t[i-1]), 40'd3);
      cycle();

      // Randomized traffic from both requesters.
      for (int k = 0; k < 400; k++) begin
         cycle();
         if (m_a_ack) begin
            if ($urandom_range(0, 1) == 1) set_a(1'b1, 7'($urandom_range(0, 7)), 8'($urandom));
            else                           set_a(1'b0, bus.a_addr, bus.a_data);
         end else if (!bus.a_req) begin
            if ($urandom_range(0, 9) < 3) set_a(1'b1, 7'($urandom_range(0, 7)), 8'($urandom));
         end else if ($urandom_range(0, 9) == 0) begin
            set_a(1'b1, 7'($urandom_range(0, 127)), 8'($urandom));
         end else if ($urandom_range(0, 19) == 0) begin
            set_a(1'b0, bus.a_addr, bus.a_data);
         end
         if (m_b_ack) begin
            if ($urandom_range(0, 1) == 1) set_b(1'b1, 7'($urandom_range(0, 7)), 8'($urandom));
            else                           set_b(1'b0, bus.b_addr, bus.b_data);
         end else if (!bus.b_req) begin
            if ($urandom_range(0, 9) < 3) set_b(1'b1, 7'($urandom_range(0, 7)), 8'($urandom));
         end else if ($urandom_range(0, 9) == 0) begin
            set_b(1'b1, 7'($urandom_range(0, 127)), 8'($urandom));
         end else if ($urandom_range(0, 19) == 0) begin
            set_b(1'b0, bus.b_addr, bus.b_data);
         end
      end
      set_a(1'b0, 7'h00, 8'h00);
      set_b(1'b0, 7'h00, 8'h00);
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
